// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instruction_fetch_unit                                       |
// | Description : PC owner and in-order fetch queue feeding decode; flushes and |
// |               restarts on a taken jump/branch from execute.                |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_ADDRESS = 32'h0000_0000,
  parameter int          BUFFER_DEPTH  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        jump_branch_enable,
  input  logic [31:0] jump_branch_address,
  output logic        imem_request,
  output logic [31:0] imem_address,
  input  logic        imem_ready,
  input  logic        imem_valid,
  input  logic [31:0] imem_data,
  output logic        instruction_valid,
  input  logic        instruction_ready,
  output logic [31:0] instruction,
  output logic [31:0] instruction_pc
);

  localparam int          CW      = $clog2(BUFFER_DEPTH) + 1;
  localparam int          PW      = $clog2(BUFFER_DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(BUFFER_DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     resp_pc_q, resp_pc_d;
  logic [CW-1:0]   occ_q, occ_d;
  logic [CW-1:0]   outs_q, outs_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [31:0]     word_q [BUFFER_DEPTH];
  logic [31:0]     tag_q  [BUFFER_DEPTH];

  logic            w_accept;
  logic            w_resp;
  logic            w_push;
  logic            w_pop;
  logic            w_credit;
  logic [CW:0]     w_sum_d;
  logic [31:0]     w_target;
  logic            w_unused;

  assign w_target = {jump_branch_address[31:2], 2'b00};
  assign w_unused = ^jump_branch_address[1:0];

  assign w_credit = (({1'b0, occ_q} + {1'b0, outs_q}) < DEPTH_W);
  assign imem_request      = (state_q == ST_FETCH) && w_credit;
  assign imem_address      = pc_q;
  assign instruction_valid = (occ_q != '0);
  assign instruction       = word_q[rd_ptr_q];
  assign instruction_pc    = tag_q[rd_ptr_q];

  // Responses are in order, so the PC of the next kept response is simply a
  // running counter reloaded with the target on redirect.
  assign w_accept = imem_request && imem_ready;
  assign w_resp   = imem_valid && (outs_q != '0);
  assign w_push   = w_resp && (drop_q == '0) && !jump_branch_enable;
  assign w_pop    = instruction_valid && instruction_ready && !jump_branch_enable;
  assign w_sum_d  = {1'b0, occ_d} + {1'b0, outs_d};

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    resp_pc_d = resp_pc_q;
    occ_d     = occ_q;
    drop_d    = drop_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    outs_d    = outs_q + CW'(w_accept) - CW'(w_resp);
    if (jump_branch_enable) begin
      pc_d      = w_target;
      resp_pc_d = w_target;
      occ_d     = '0;
      drop_d    = outs_d;
      wr_ptr_d  = rd_ptr_q;
      state_d   = ST_FETCH;
    end else begin
      if (w_accept) begin
        pc_d = pc_q + 32'd4;
      end
      if (w_resp && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
      if (w_push) begin
        wr_ptr_d  = wr_ptr_q + PW'(1);
        resp_pc_d = resp_pc_q + 32'd4;
      end
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      occ_d = occ_q + CW'(w_push) - CW'(w_pop);
      case (state_q)
        ST_IDLE:  state_d = ST_FETCH;
        ST_FETCH: state_d = (w_sum_d < DEPTH_W) ? ST_FETCH : ST_HOLD;
        ST_HOLD:  state_d = (w_sum_d < DEPTH_W) ? ST_FETCH : ST_HOLD;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_ADDRESS;
      resp_pc_q <= RESET_ADDRESS;
      occ_q     <= '0;
      outs_q    <= '0;
      drop_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      occ_q     <= occ_d;
      outs_q    <= outs_d;
      drop_q    <= drop_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < BUFFER_DEPTH; i++) begin
        word_q[i] <= NOP;
        tag_q[i]  <= 32'h0000_0000;
      end
    end else if (w_push) begin
      word_q[wr_ptr_q] <= imem_data;
      tag_q[wr_ptr_q]  <= resp_pc_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_instruction_fetch_unit                                    |
// | Description : Directed bench with memory model and delivery scoreboard.    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_instruction_fetch_unit;

  localparam logic [31:0] RESET_ADDRESS = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        jump_branch_enable;
  logic [31:0] jump_branch_address;
  logic        imem_request;
  logic [31:0] imem_address;
  logic        imem_ready;
  logic        imem_valid;
  logic [31:0] imem_data;
  logic        instruction_valid;
  logic        instruction_ready;
  logic [31:0] instruction;
  logic [31:0] instruction_pc;

  int checks   = 0;
  int failures = 0;
  int acc_count = 0;

  logic        mem_hold = 1'b0;
  logic        rst_cap  = 1'b1;
  logic        hold_cap = 1'b0;
  logic [31:0] mem_q [$];
  logic [31:0] exp_q [$];
  logic [31:0] acc_log [$];
  logic [31:0] exp_fetch = RESET_ADDRESS;

  instruction_fetch_unit #(
    .RESET_ADDRESS (RESET_ADDRESS),
    .BUFFER_DEPTH  (2)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .jump_branch_enable  (jump_branch_enable),
    .jump_branch_address (jump_branch_address),
    .imem_request        (imem_request),
    .imem_address        (imem_address),
    .imem_ready          (imem_ready),
    .imem_valid          (imem_valid),
    .imem_data           (imem_data),
    .instruction_valid   (instruction_valid),
    .instruction_ready   (instruction_ready),
    .instruction         (instruction),
    .instruction_pc      (instruction_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (instruction_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk(tag, {31'b0, instruction_valid}, 32'd1);
  endtask

  // Scoreboard: evaluated at the falling edge for the handshakes of the next rising edge
  always @(negedge clk) begin
    logic [31:0] e;
    rst_cap  = !reset;
    hold_cap = mem_hold;
    if (!reset) begin
      mem_q.delete();
      exp_q.delete();
      exp_fetch = RESET_ADDRESS;
    end else begin
      if (imem_request && imem_ready) begin
        chk("fetch_addr", imem_address, exp_fetch);
        mem_q.push_back(imem_address);
        acc_count++;
        if (!jump_branch_enable) acc_log.push_back(imem_address);
        exp_q.push_back(exp_fetch);
        exp_fetch = exp_fetch + 32'd4;
      end
      if (jump_branch_enable) begin
        exp_q.delete();
        exp_fetch = {jump_branch_address[31:2], 2'b00};
      end else if (instruction_valid && instruction_ready) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          failures++;
          $error("FAIL deliver_unexpected observed_pc=%h expected=none", instruction_pc);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("deliver_pc", instruction_pc, e);
          chk("deliver_word", instruction, mem_word(e));
        end
      end
    end
  end

  // One-cycle-latency memory, stallable by mem_hold
  always @(posedge clk) begin
    logic [31:0] a;
    #1;
    if (rst_cap || hold_cap || mem_q.size() == 0) begin
      imem_valid = 1'b0;
    end else begin
      a = mem_q.pop_front();
      imem_data  = mem_word(a);
      imem_valid = 1'b1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    int   a_before;
    reset = 1'b0;
    jump_branch_enable = 1'b0;
    jump_branch_address = 32'h0;
    imem_ready = 1'b1;
    instruction_ready = 1'b1;
    imem_valid = 1'b0;
    imem_data = 32'h0;

    // Reset state
    tick(); tick(); tick();
    chk("rst_request", {31'b0, imem_request}, 32'd0);
    chk("rst_address", imem_address, RESET_ADDRESS);
    chk("rst_valid", {31'b0, instruction_valid}, 32'd0);
    chk("rst_instr", instruction, 32'h0000_0013);
    chk("rst_pc", instruction_pc, 32'h0);
    reset = 1'b1;
    tick();
    chk("start_request", {31'b0, imem_request}, 32'd1);
    chk("start_address", imem_address, RESET_ADDRESS);

    // Streaming; first word visible one cycle after its response
    tick();
    chk("t1_no_bypass", {31'b0, instruction_valid}, 32'd0);
    tick();
    chk("t1_first_valid", {31'b0, instruction_valid}, 32'd1);
    chk("t1_first_pc", instruction_pc, RESET_ADDRESS);
    repeat (10) tick();

    // Decode stall fills the queue and stops fetching
    instruction_ready = 1'b0;
    repeat (6) tick();
    chk("t2_hold_request", {31'b0, imem_request}, 32'd0);
    chk("t2_hold_valid", {31'b0, instruction_valid}, 32'd1);
    a_before = acc_count;
    repeat (4) tick();
    chk("t2_no_accepts", acc_count, a_before);
    instruction_ready = 1'b1;
    tick();
    instruction_ready = 1'b0;
    chk("t2_refetch_request", {31'b0, imem_request}, 32'd1);
    repeat (4) tick();
    chk("t2_one_accept", acc_count, a_before + 1);
    chk("t2_rehold_request", {31'b0, imem_request}, 32'd0);

    // Redirect with two responses still outstanding
    instruction_ready = 1'b1;
    mem_hold = 1'b1;
    repeat (8) tick();
    chk("t3_credit_full", {31'b0, imem_request}, 32'd0);
    chk("t3_drained", {31'b0, instruction_valid}, 32'd0);
    jump_branch_enable = 1'b1;
    jump_branch_address = 32'h0000_0100;
    tick();
    jump_branch_enable = 1'b0;
    mem_hold = 1'b0;
    chk("t3_wait_drops", {31'b0, imem_request}, 32'd0);
    wait_valid("t3_wait");
    chk("t3_target_pc", instruction_pc, 32'h0000_0100);
    chk("t3_target_word", instruction, mem_word(32'h0000_0100));

    // Redirect coinciding with a response and a pop
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (imem_valid && instruction_valid) found = 1'b1;
      else tick();
    end
    chk("t4_setup", {31'b0, found}, 32'd1);
    jump_branch_enable = 1'b1;
    jump_branch_address = 32'h0000_0200;
    tick();
    jump_branch_enable = 1'b0;
    chk("t4_flushed", {31'b0, instruction_valid}, 32'd0);
    wait_valid("t4_wait");
    chk("t4_target_pc", instruction_pc, 32'h0000_0200);

    // PC wrap, with a misaligned target
    jump_branch_enable = 1'b1;
    jump_branch_address = 32'hFFFF_FFFB;
    acc_log.delete();
    tick();
    jump_branch_enable = 1'b0;
    repeat (10) tick();
    chk("t5_accepts", {31'b0, acc_log.size() >= 3}, 32'd1);
    if (acc_log.size() >= 3) begin
      chk("t5_addr0", acc_log[0], 32'hFFFF_FFF8);
      chk("t5_addr1", acc_log[1], 32'hFFFF_FFFC);
      chk("t5_addr2", acc_log[2], 32'h0000_0000);
    end

    // Reset with the queue full
    instruction_ready = 1'b0;
    repeat (8) tick();
    chk("t6_full_valid", {31'b0, instruction_valid}, 32'd1);
    chk("t6_full_request", {31'b0, imem_request}, 32'd0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    instruction_ready = 1'b1;
    chk("t6_rst_valid", {31'b0, instruction_valid}, 32'd0);
    chk("t6_rst_request", {31'b0, imem_request}, 32'd0);
    chk("t6_rst_address", imem_address, RESET_ADDRESS);
    chk("t6_rst_instr", instruction, 32'h0000_0013);
    tick();
    chk("t6_restart_request", {31'b0, imem_request}, 32'd1);
    chk("t6_restart_address", imem_address, RESET_ADDRESS);
    wait_valid("t6_wait");
    chk("t6_restart_pc", instruction_pc, RESET_ADDRESS);
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
